comet_ii_mem_interface: RTL and testbench

- Memory bus unit between the COMET II CPU and word-addressed RAM.
- Arbitrates between two requesters: the instruction-fetch path (driven by the controller's IFETCH stage) and the data path (operand read, store, push, pop).
- Runs one variable-latency RAM access at a time, with a ready handshake and a wait-state timeout.
- Presents a held 16-bit `rdata` word that the controller and datapath consume.

---
 rtl/comet_ii_mem_interface.sv | 165 ++++++++++++++++
 tb/tb_comet_ii_mem_interface.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/comet_ii_mem_interface.sv
// COMET II memory bus unit: arbitrates fetch and data requests onto a single
// word-addressed RAM port with a ready handshake and a wait-state timeout.
module comet_ii_mem_interface #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_err,
  output logic              busy,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;
  localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);

  logic [1:0]        state_q, state_d;
  logic              owner_data_q, owner_data_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              bus_err_q, bus_err_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              busy_q, busy_d;

  // Next-state and next-output computation for the access FSM.
  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    cnt_d        = cnt_q;
    mem_cs_d     = mem_cs_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    bus_err_d    = bus_err_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req) begin
          owner_data_d = 1'b1;
          mem_we_d     = d_we;
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
          mem_cs_d     = 1'b1;
          cnt_d        = 8'd0;
          state_d      = WAIT;
        end else if (if_req) begin
          owner_data_d = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_cs_d     = 1'b1;
          cnt_d        = 8'd0;
          state_d      = WAIT;
        end else begin
          mem_cs_d = 1'b0;
        end
      end
      WAIT: begin
        if (mem_ready) begin
          if (!mem_we_q) begin
            rdata_d = mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          mem_cs_d = 1'b0;
          mem_we_d = 1'b0;
          if_ack_d = ~owner_data_q;
          d_ack_d  = owner_data_q;
          state_d  = ACK;
        end else if (cnt_q == WAIT_MAX_C) begin
          // Timeout: poison read data and complete the access anyway.
          if (!mem_we_q) begin
            rdata_d = {DATA_W{1'b1}};
          end else begin
            rdata_d = rdata_q;
          end
          bus_err_d = 1'b1;
          mem_cs_d  = 1'b0;
          mem_we_d  = 1'b0;
          if_ack_d  = ~owner_data_q;
          d_ack_d   = owner_data_q;
          state_d   = ACK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        mem_cs_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge mclk) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_data_q <= 1'b0;
      cnt_q        <= 8'd0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      rdata_q      <= {DATA_W{1'b0}};
      bus_err_q    <= 1'b0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      cnt_q        <= cnt_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      bus_err_q    <= bus_err_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      busy_q       <= busy_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign rdata     = rdata_q;
  assign bus_err   = bus_err_q;
  assign busy      = busy_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_comet_ii_mem_interface.sv
// Directed bench for comet_ii_mem_interface; the bench drives RAM ready/data
// directly and checks registered outputs 1 time unit after each rising edge.
module tb_comet_ii_mem_interface;

  logic        mclk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] rdata;
  logic        bus_err;
  logic        busy;
  logic        mem_cs;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;
  int cs_cycles;

  comet_ii_mem_interface #(.ADDR_W(16), .DATA_W(16), .WAIT_MAX(15)) dut (
    .mclk(mclk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .bus_err(bus_err), .busy(busy),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = 16'h0000; d_req = 1'b0; d_we = 1'b0;
    d_addr = 16'h0000; d_wdata = 16'h0000; mem_rdata = 16'h0000; mem_ready = 1'b0;
    tick(); tick();
    check("rst_cs", 32'(mem_cs), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    rst = 1'b1;
    tick();

    // Zero-wait read
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
    tick();
    check("zw_cs", 32'(mem_cs), 32'd1);
    check("zw_we", 32'(mem_we), 32'd0);
    check("zw_addr", 32'(mem_addr), 32'h0010);
    check("zw_busy", 32'(busy), 32'd1);
    check("zw_ack_early", 32'(d_ack), 32'd0);
    d_req = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h1234;
    tick();
    check("zw_cs_off", 32'(mem_cs), 32'd0);
    check("zw_dack", 32'(d_ack), 32'd1);
    check("zw_ifack", 32'(if_ack), 32'd0);
    check("zw_rdata", 32'(rdata), 32'h1234);
    mem_ready = 1'b0; mem_rdata = 16'h0000;
    tick();
    check("zw_dack_off", 32'(d_ack), 32'd0);
    check("zw_idle", 32'(busy), 32'd0);
    tick();
    check("zw_rdata_hold", 32'(rdata), 32'h1234);

    // Write with 3 wait states; requester changes address/data mid-access
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h00FF; d_wdata = 16'hBEEF;
    tick();
    d_req = 1'b0; d_addr = 16'h1111; d_wdata = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      check("wr_cs", 32'(mem_cs), 32'd1);
      check("wr_we", 32'(mem_we), 32'd1);
      check("wr_addr", 32'(mem_addr), 32'h00FF);
      check("wr_wdata", 32'(mem_wdata), 32'hBEEF);
      check("wr_dack_early", 32'(d_ack), 32'd0);
      if (i == 3) mem_ready = 1'b1;
      else mem_ready = 1'b0;
      tick();
    end
    mem_ready = 1'b0;
    check("wr_cs_off", 32'(mem_cs), 32'd0);
    check("wr_dack", 32'(d_ack), 32'd1);
    check("wr_rdata_kept", 32'(rdata), 32'h1234);
    tick();
    check("wr_dack_off", 32'(d_ack), 32'd0);

    // Arbitration: simultaneous requests, data first
    d_we = 1'b0; if_addr = 16'h0100; d_addr = 16'h0200;
    if_req = 1'b1; d_req = 1'b1;
    tick();
    check("arb1_addr", 32'(mem_addr), 32'h0200);
    check("arb1_cs", 32'(mem_cs), 32'd1);
    d_req = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hAAAA;
    tick();
    check("arb1_acks", {30'd0, if_ack, d_ack}, 32'd1);
    check("arb1_rdata", 32'(rdata), 32'hAAAA);
    mem_ready = 1'b0;
    tick();
    check("arb_gap_acks", {30'd0, if_ack, d_ack}, 32'd0);
    check("arb_gap_cs", 32'(mem_cs), 32'd0);
    tick();
    check("arb2_addr", 32'(mem_addr), 32'h0100);
    check("arb2_cs", 32'(mem_cs), 32'd1);
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h5555;
    tick();
    check("arb2_acks", {30'd0, if_ack, d_ack}, 32'd2);
    check("arb2_rdata", 32'(rdata), 32'h5555);
    mem_ready = 1'b0;
    tick();
    check("arb2_acks_off", {30'd0, if_ack, d_ack}, 32'd0);

    // Timeout: fetch read with mem_ready never asserted
    if_req = 1'b1; if_addr = 16'h0300;
    tick();
    if_req = 1'b0;
    cs_cycles = 0;
    for (int i = 0; i < 40 && mem_cs; i++) begin
      if (if_ack) check("to_ack_early", 32'(if_ack), 32'd0);
      cs_cycles++;
      tick();
    end
    check("to_cs_cycles", 32'(cs_cycles), 32'd16);
    check("to_ifack", 32'(if_ack), 32'd1);
    check("to_dack", 32'(d_ack), 32'd0);
    check("to_rdata", 32'(rdata), 32'hFFFF);
    check("to_err", 32'(bus_err), 32'd1);
    tick();
    check("to_ifack_off", 32'(if_ack), 32'd0);
    check("to_err_sticky", 32'(bus_err), 32'd1);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    tick();
    check("post_to_cs", 32'(mem_cs), 32'd1);
    d_req = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h4321;
    tick();
    check("post_to_dack", 32'(d_ack), 32'd1);
    check("post_to_rdata", 32'(rdata), 32'h4321);
    check("post_to_err", 32'(bus_err), 32'd1);
    mem_ready = 1'b0;
    tick();

    // Reset during the 2nd WAIT cycle
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030;
    tick();
    d_req = 1'b0;
    tick();
    check("rm_cs_before", 32'(mem_cs), 32'd1);
    rst = 1'b0;
    tick();
    check("rm_cs", 32'(mem_cs), 32'd0);
    check("rm_acks", {30'd0, if_ack, d_ack}, 32'd0);
    check("rm_rdata", 32'(rdata), 32'h0);
    check("rm_err", 32'(bus_err), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_addr", 32'(mem_addr), 32'h0);
    rst = 1'b1;
    tick();
    check("rm_no_ack", {30'd0, if_ack, d_ack}, 32'd0);
    if_req = 1'b1; if_addr = 16'h0040;
    tick();
    check("rm_new_cs", 32'(mem_cs), 32'd1);
    check("rm_new_addr", 32'(mem_addr), 32'h0040);
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h0BAD;
    tick();
    check("rm_new_ifack", 32'(if_ack), 32'd1);
    check("rm_new_rdata", 32'(rdata), 32'h0BAD);
    mem_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
